// File: rtl/lane_word_packer_if.sv
// Stream bundle for lane_word_packer: beat input on the in_* side, packed word on the out_* side.
// The packer takes the slave modport; the feeder/consumer pair takes master.
interface lane_word_packer_if #(
   parameter int LANES      = 4,
   parameter int LANE_WIDTH = 8,
   parameter int TAG_WIDTH  = 4
) ();
   logic                               in_valid;
   logic                               in_ready;
   logic [LANE_WIDTH-1:0]              in_data;
   logic [TAG_WIDTH-1:0]               in_tag;
   logic                               in_last;
   logic                               out_valid;
   logic                               out_ready;
   logic [0:LANES-1][0:LANE_WIDTH-1]   out_lanes;
   logic [TAG_WIDTH-1:0]               out_tag;
   logic [0:LANES-1]                   out_lane_mask;

   modport slave (
      input  in_valid, in_data, in_tag, in_last, out_ready,
      output in_ready, out_valid, out_lanes, out_tag, out_lane_mask
   );

   modport master (
      output in_valid, in_data, in_tag, in_last, out_ready,
      input  in_ready, out_valid, out_lanes, out_tag, out_lane_mask
   );
endinterface

// File: rtl/lane_word_packer.sv
// Packs serial LANE_WIDTH-bit beats into a [0:LANES-1] lane word with tag and lane mask.
// One fill buffer plus one output register; a full fill buffer parks in FULL until the slot frees.
//
// state  | meaning
// S_FILL | accepting beats into the fill buffer (in_ready=1)
// S_FULL | fill buffer holds a complete word waiting for the output slot (in_ready=0)
module lane_word_packer #(
   parameter int LANES      = 4,
   parameter int LANE_WIDTH = 8,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   lane_word_packer_if.slave   bus
);
   localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

   typedef logic [0:LANES-1][0:LANE_WIDTH-1] lanes_t;
   typedef enum logic {S_FILL, S_FULL} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [IDXW-1:0]        r_idx;
   lanes_t                 r_fill_lanes;
   logic [0:LANES-1]       r_fill_mask;
   logic [TAG_WIDTH-1:0]   r_fill_tag;
   logic                   r_out_valid;
   lanes_t                 r_out_lanes;
   logic [0:LANES-1]       r_out_mask;
   logic [TAG_WIDTH-1:0]   r_out_tag;

   lanes_t                 w_asm_lanes;
   logic [0:LANES-1]       w_asm_mask;
   logic [TAG_WIDTH-1:0]   w_asm_tag;
   logic                   w_beat;
   logic                   w_complete;
   logic                   w_slot_free;
   logic                   w_in_ready;
   logic                   w_load;
   logic                   w_load_from_fill;

   assign w_beat      = bus.in_valid && (r_state == S_FILL);
   assign w_complete  = w_beat && ((r_idx == LAST_IDX) || bus.in_last);
   assign w_slot_free = !r_out_valid || bus.out_ready;

   // First beat of a word starts from a cleared buffer so short words leave zero lanes.
   always_comb begin
      w_asm_lanes        = (r_idx == '0) ? '0 : r_fill_lanes;
      w_asm_mask         = (r_idx == '0) ? '0 : r_fill_mask;
      w_asm_tag          = (r_idx == '0) ? bus.in_tag : r_fill_tag;
      w_asm_lanes[r_idx] = bus.in_data;
      w_asm_mask[r_idx]  = 1'b1;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_in_ready       = 1'b0;
      w_load           = 1'b0;
      w_load_from_fill = 1'b0;
      case (r_state)
         S_FILL: begin
            w_in_ready = 1'b1;
            if (w_complete) begin
               if (w_slot_free) w_load = 1'b1;
               else             w_state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            if (w_slot_free) begin
               w_load           = 1'b1;
               w_load_from_fill = 1'b1;
               w_state_nxt      = S_FILL;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_FILL;
         r_idx        <= '0;
         r_fill_lanes <= '0;
         r_fill_mask  <= '0;
         r_fill_tag   <= '0;
         r_out_valid  <= 1'b0;
         r_out_lanes  <= '0;
         r_out_mask   <= '0;
         r_out_tag    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_beat) begin
            r_fill_lanes <= w_asm_lanes;
            r_fill_mask  <= w_asm_mask;
            r_fill_tag   <= w_asm_tag;
            if (!w_complete)     r_idx <= r_idx + 1'b1;
            else if (w_slot_free) r_idx <= '0;
         end else if (w_load) begin
            r_idx <= '0;
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_lanes <= w_load_from_fill ? r_fill_lanes : w_asm_lanes;
            r_out_mask  <= w_load_from_fill ? r_fill_mask  : w_asm_mask;
            r_out_tag   <= w_load_from_fill ? r_fill_tag   : w_asm_tag;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_lanes     = r_out_lanes;
   assign bus.out_tag       = r_out_tag;
   assign bus.out_lane_mask = r_out_mask;
endmodule
